// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
//   Shared types and constants for the two-requester SRAM port arbiter.
//   - state_e : arbiter sequencing states
//   - grant_e : which requester currently owns the SRAM port
//   - addr_in_range() : checks that a byte address falls inside the macro
// ---------------------------------------------------------------------------
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    GNT_CPU,
    GNT_DMA
  } grant_e;

  localparam int SRAM_WORDS  = 512;
  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_MASK_W = 4;

  // True when (addr - base) lies within the 2^aw word window. Any bit above
  // the word index plus the byte offset means the access misses the macro.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int          aw);
    logic [31:0] off;
    off = addr - base;
    return (off >> (aw + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-input round-robin grant. The grant is combinational from the current
//   requests and the last_grant register; last_grant only moves when the
//   parent accepts the grant (i_update).
// Ports:
//   clk, resetn  : clock, asynchronous active-low reset
//   i_cpu_req    : CPU request
//   i_dma_req    : DMA request
//   i_update     : parent latched the grant this edge
//   o_grant      : requester that wins now
//   o_any        : at least one request pending
// ---------------------------------------------------------------------------
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic   clk,
  input  logic   resetn,
  input  logic   i_cpu_req,
  input  logic   i_dma_req,
  input  logic   i_update,
  output grant_e o_grant,
  output logic   o_any
);

  grant_e r_last;

  always_comb begin
    o_any   = i_cpu_req | i_dma_req;
    o_grant = GNT_CPU;
    if (i_cpu_req && i_dma_req) begin
      // Tie: the side that did not win last time goes next.
      o_grant = (r_last == GNT_CPU) ? GNT_DMA : GNT_CPU;
    end else if (i_dma_req) begin
      o_grant = GNT_DMA;
    end
  end

  // Reset to DMA so the CPU wins the very first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last <= GNT_DMA;
    end else if (i_update && o_any) begin
      r_last <= o_grant;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//   Shares port 0 of the 32x512 SRAM macro between the CPU native memory bus
//   and a DMA/debug master. Each access is sequenced IDLE -> ACCESS ->
//   (WAIT for reads) -> RESP, with a one-cycle ready pulse in RESP.
//   Out-of-range accesses skip the SRAM and go straight to RESP with err.
//   All outputs come straight from registers.
// Ports:
//   clk, resetn                    : clock, asynchronous active-low reset
//   cpu_valid/addr/wdata/wstrb     : CPU request (wstrb==0 is a read)
//   cpu_ready, cpu_rdata           : CPU completion pulse and read data
//   dma_valid/addr/wdata/wstrb     : DMA request (wstrb==0 is a read)
//   dma_ready, dma_rdata           : DMA completion pulse and read data
//   sram_csb/web/wmask/addr/din    : SRAM port 0 controls (csb/web active low)
//   sram_dout                      : SRAM port 0 read data
//   err                            : one-cycle pulse on an out-of-range access
// ---------------------------------------------------------------------------
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 9,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cpu_valid,
  input  logic [31:0]            cpu_addr,
  input  logic [SRAM_DATA_W-1:0] cpu_wdata,
  input  logic [SRAM_MASK_W-1:0] cpu_wstrb,
  output logic                   cpu_ready,
  output logic [SRAM_DATA_W-1:0] cpu_rdata,
  input  logic                   dma_valid,
  input  logic [31:0]            dma_addr,
  input  logic [SRAM_DATA_W-1:0] dma_wdata,
  input  logic [SRAM_MASK_W-1:0] dma_wstrb,
  output logic                   dma_ready,
  output logic [SRAM_DATA_W-1:0] dma_rdata,
  output logic                   sram_csb,
  output logic                   sram_web,
  output logic [SRAM_MASK_W-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_din,
  input  logic [SRAM_DATA_W-1:0] sram_dout,
  output logic                   err
);

  state_e                   r_state,     w_state_next;
  grant_e                   r_gnt,       w_gnt_next;
  logic [1:0]               r_cnt,       w_cnt_next;
  logic                     r_csb,       w_csb_next;
  logic                     r_web,       w_web_next;
  logic [SRAM_MASK_W-1:0]   r_wmask,     w_wmask_next;
  logic [ADDR_WIDTH-1:0]    r_addr,      w_addr_next;
  logic [SRAM_DATA_W-1:0]   r_din,       w_din_next;
  logic                     r_cpu_ready, w_cpu_ready_next;
  logic                     r_dma_ready, w_dma_ready_next;
  logic                     r_err,       w_err_next;
  logic [SRAM_DATA_W-1:0]   r_cpu_rdata, w_cpu_rdata_next;
  logic [SRAM_DATA_W-1:0]   r_dma_rdata, w_dma_rdata_next;

  grant_e                   w_gnt;
  logic                     w_any;
  logic                     w_arb_en;
  logic [31:0]              w_sel_addr;
  logic [SRAM_DATA_W-1:0]   w_sel_wdata;
  logic [SRAM_MASK_W-1:0]   w_sel_wstrb;
  logic                     w_in_range;
  logic [ADDR_WIDTH-1:0]    w_word;

  rr_arb2 u_arb (
    .clk       (clk),
    .resetn    (resetn),
    .i_cpu_req (cpu_valid),
    .i_dma_req (dma_valid),
    .i_update  (w_arb_en),
    .o_grant   (w_gnt),
    .o_any     (w_any)
  );

  // Request fields of whichever side the arbiter would grant this cycle.
  always_comb begin
    w_sel_addr  = (w_gnt == GNT_CPU) ? cpu_addr  : dma_addr;
    w_sel_wdata = (w_gnt == GNT_CPU) ? cpu_wdata : dma_wdata;
    w_sel_wstrb = (w_gnt == GNT_CPU) ? cpu_wstrb : dma_wstrb;
    w_in_range  = addr_in_range(w_sel_addr, BASE_ADDR, ADDR_WIDTH);
    w_word      = ADDR_WIDTH'((w_sel_addr - BASE_ADDR) >> 2);
  end

  always_comb begin
    w_state_next     = r_state;
    w_gnt_next       = r_gnt;
    w_cnt_next       = r_cnt;
    // csb/web default high so the strobe lasts exactly the ACCESS cycle.
    w_csb_next       = 1'b1;
    w_web_next       = 1'b1;
    w_wmask_next     = r_wmask;
    w_addr_next      = r_addr;
    w_din_next       = r_din;
    w_cpu_ready_next = 1'b0;
    w_dma_ready_next = 1'b0;
    w_err_next       = 1'b0;
    w_cpu_rdata_next = r_cpu_rdata;
    w_dma_rdata_next = r_dma_rdata;
    w_arb_en         = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_arb_en   = 1'b1;
          w_gnt_next = w_gnt;
          if (w_in_range) begin
            w_state_next = ACCESS;
            w_csb_next   = 1'b0;
            w_addr_next  = w_word;
            if (w_sel_wstrb != '0) begin
              w_web_next   = 1'b0;
              w_wmask_next = w_sel_wstrb;
              w_din_next   = w_sel_wdata;
            end else begin
              w_wmask_next = '0;
            end
          end else begin
            // Miss: no SRAM cycle, answer immediately with zero data.
            w_state_next = RESP;
            w_err_next   = 1'b1;
            if (w_gnt == GNT_CPU) begin
              w_cpu_ready_next = 1'b1;
              w_cpu_rdata_next = '0;
            end else begin
              w_dma_ready_next = 1'b1;
              w_dma_rdata_next = '0;
            end
          end
        end
      end

      ACCESS: begin
        // r_web still holds the value presented to the SRAM this cycle.
        if (!r_web) begin
          w_state_next = RESP;
          if (r_gnt == GNT_CPU) w_cpu_ready_next = 1'b1;
          else                  w_dma_ready_next = 1'b1;
        end else begin
          w_state_next = WAIT;
          w_cnt_next   = 2'(READ_LATENCY - 1);
        end
      end

      WAIT: begin
        if (r_cnt == 2'd0) begin
          w_state_next = RESP;
          if (r_gnt == GNT_CPU) begin
            w_cpu_ready_next = 1'b1;
            w_cpu_rdata_next = sram_dout;
          end else begin
            w_dma_ready_next = 1'b1;
            w_dma_rdata_next = sram_dout;
          end
        end else begin
          w_cnt_next = r_cnt - 2'd1;
        end
      end

      RESP: begin
        // Never re-grant here: the requester's valid is still up this cycle.
        w_state_next = IDLE;
      end

      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_gnt       <= GNT_CPU;
      r_cnt       <= 2'd0;
      r_csb       <= 1'b1;
      r_web       <= 1'b1;
      r_wmask     <= '0;
      r_addr      <= '0;
      r_din       <= '0;
      r_cpu_ready <= 1'b0;
      r_dma_ready <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_state     <= w_state_next;
      r_gnt       <= w_gnt_next;
      r_cnt       <= w_cnt_next;
      r_csb       <= w_csb_next;
      r_web       <= w_web_next;
      r_wmask     <= w_wmask_next;
      r_addr      <= w_addr_next;
      r_din       <= w_din_next;
      r_cpu_ready <= w_cpu_ready_next;
      r_dma_ready <= w_dma_ready_next;
      r_err       <= w_err_next;
      r_cpu_rdata <= w_cpu_rdata_next;
      r_dma_rdata <= w_dma_rdata_next;
    end
  end

  assign sram_csb   = r_csb;
  assign sram_web   = r_web;
  assign sram_wmask = r_wmask;
  assign sram_addr  = r_addr;
  assign sram_din   = r_din;
  assign cpu_ready  = r_cpu_ready;
  assign dma_ready  = r_dma_ready;
  assign cpu_rdata  = r_cpu_rdata;
  assign dma_rdata  = r_dma_rdata;
  assign err        = r_err;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
//   Directed bench for sram_port_arbiter. u_dut uses READ_LATENCY=1,
//   u_dut3 uses READ_LATENCY=3; each has a small behavioural SRAM whose read
//   data becomes valid exactly READ_LATENCY edges after the capture edge.
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        tb_init;

  logic        cpu_valid, dma_valid;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [3:0]  cpu_wstrb, dma_wstrb;
  logic        cpu_ready, dma_ready;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        sram_csb, sram_web, err;
  logic [3:0]  sram_wmask;
  logic [8:0]  sram_addr;
  logic [31:0] sram_din, sram_dout;

  logic        c3_valid, d3_valid;
  logic [31:0] c3_addr, c3_wdata, d3_addr, d3_wdata;
  logic [3:0]  c3_wstrb, d3_wstrb;
  logic        c3_ready, d3_ready;
  logic [31:0] c3_rdata, d3_rdata;
  logic        s3_csb, s3_web, err3;
  logic [3:0]  s3_wmask;
  logic [8:0]  s3_addr;
  logic [31:0] s3_din, s3_dout;

  sram_port_arbiter #(.ADDR_WIDTH(9), .BASE_ADDR(32'h0), .READ_LATENCY(1)) u_dut (
    .clk(clk), .resetn(resetn),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .dma_valid(dma_valid), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_wstrb(dma_wstrb),
    .dma_ready(dma_ready), .dma_rdata(dma_rdata),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout), .err(err)
  );

  sram_port_arbiter #(.ADDR_WIDTH(9), .BASE_ADDR(32'h0), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .resetn(resetn),
    .cpu_valid(c3_valid), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata), .cpu_wstrb(c3_wstrb),
    .cpu_ready(c3_ready), .cpu_rdata(c3_rdata),
    .dma_valid(d3_valid), .dma_addr(d3_addr), .dma_wdata(d3_wdata), .dma_wstrb(d3_wstrb),
    .dma_ready(d3_ready), .dma_rdata(d3_rdata),
    .sram_csb(s3_csb), .sram_web(s3_web), .sram_wmask(s3_wmask), .sram_addr(s3_addr),
    .sram_din(s3_din), .sram_dout(s3_dout), .err(err3)
  );

  // SRAM model, 1-edge read latency. Word 4 starts at zero, others 0xA5000000|i.
  logic [31:0] mem [0:511];
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= (i == 4) ? 32'h0 : (32'hA500_0000 | 32'(i));
    end else if (!sram_csb && !sram_web) begin
      for (int b = 0; b < 4; b++)
        if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
    end
    sram_dout <= (!sram_csb && sram_web) ? mem[sram_addr] : 32'hBAD0_BAD0;
  end

  // SRAM model, 3-edge read latency (read-only here).
  logic [31:0] mem3 [0:511];
  logic [31:0] p3 [0:2];
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 512; i++) mem3[i] <= (i == 4) ? 32'h0000_BEEF : (32'hA500_0000 | 32'(i));
    end
    p3[0] <= (!s3_csb && s3_web) ? mem3[s3_addr] : 32'hBAD0_BAD0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign s3_dout = p3[2];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Results of the last do_xfer call.
  int          x_lat, x_ncs;
  logic [31:0] x_rd, x_din;
  logic        x_err, x_other, x_web, x_post_rdy, x_post_csb;
  logic [3:0]  x_wm;
  logic [8:0]  x_addr;

  // Issue one request from the current negedge; latency k means ready is
  // seen at the k-th negedge after the valid-sampling edge.
  task automatic do_xfer(input bit is_dma, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws);
    logic my_rdy;
    x_lat = 0; x_ncs = 0; x_rd = 32'hFFFF_FFFF; x_err = 0; x_other = 0;
    x_web = 1'bx; x_wm = 4'hx; x_addr = 9'hx; x_din = 32'hx;
    if (is_dma) begin
      dma_addr = a; dma_wdata = wd; dma_wstrb = ws; dma_valid = 1'b1;
    end else begin
      cpu_addr = a; cpu_wdata = wd; cpu_wstrb = ws; cpu_valid = 1'b1;
    end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (!sram_csb) begin
        x_ncs++;
        x_web = sram_web; x_wm = sram_wmask; x_addr = sram_addr; x_din = sram_din;
      end
      if (err) x_err = 1'b1;
      if (is_dma ? cpu_ready : dma_ready) x_other = 1'b1;
      my_rdy = is_dma ? dma_ready : cpu_ready;
      if (my_rdy) begin
        x_lat = k;
        x_rd  = is_dma ? dma_rdata : cpu_rdata;
        break;
      end
    end
    @(negedge clk);
    x_post_rdy = is_dma ? dma_ready : cpu_ready;
    x_post_csb = sram_csb;
    if (is_dma) dma_valid = 1'b0;
    else        cpu_valid = 1'b0;
  endtask

  initial begin
    int nc, nd, n, both, hits, lat3;
    bit cpu_pend, dma_pend;
    logic [31:0] rd3;

    resetn = 1'b0; tb_init = 1'b1;
    cpu_valid = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0;
    dma_valid = 0; dma_addr = 0; dma_wdata = 0; dma_wstrb = 0;
    c3_valid = 0; c3_addr = 0; c3_wdata = 0; c3_wstrb = 0;
    d3_valid = 0; d3_addr = 0; d3_wdata = 0; d3_wstrb = 0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_csb",   32'(sram_csb),   32'd1);
    check("rst_web",   32'(sram_web),   32'd1);
    check("rst_wmask", 32'(sram_wmask), 32'd0);
    check("rst_addr",  32'(sram_addr),  32'd0);
    check("rst_din",   sram_din,        32'd0);
    check("rst_ready", 32'({cpu_ready, dma_ready, err}), 32'd0);
    check("rst_rdata", cpu_rdata | dma_rdata, 32'd0);
    tb_init = 1'b0; resetn = 1'b1;
    @(negedge clk);

    // CPU partial write: word 4, low half-word
    do_xfer(0, 32'h10, 32'hDEAD_BEEF, 4'b0011);
    check("wr_lat",   32'(x_lat),  32'd2);
    check("wr_ncs",   32'(x_ncs),  32'd1);
    check("wr_web",   32'(x_web),  32'd0);
    check("wr_addr",  32'(x_addr), 32'd4);
    check("wr_wmask", 32'(x_wm),   32'd3);
    check("wr_din",   x_din,       32'hDEAD_BEEF);
    check("wr_other", 32'(x_other), 32'd0);
    check("wr_err",   32'(x_err),   32'd0);
    $display("xfer cpu wr addr=0x10 lat=%0d", x_lat);

    // CPU read back, READ_LATENCY=1
    do_xfer(0, 32'h10, 32'h0, 4'b0000);
    check("rd1_lat",   32'(x_lat), 32'd3);
    check("rd1_data",  x_rd,       32'h0000_BEEF);
    check("rd1_web",   32'(x_web), 32'd1);
    check("rd1_wmask", 32'(x_wm),  32'd0);
    $display("xfer cpu rd addr=0x10 lat=%0d data=0x%08h", x_lat, x_rd);

    // CPU read, READ_LATENCY=3
    c3_addr = 32'h10; c3_wstrb = 4'b0000; c3_valid = 1'b1;
    lat3 = 0; rd3 = 32'hFFFF_FFFF;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (c3_ready) begin lat3 = k; rd3 = c3_rdata; break; end
    end
    @(negedge clk);
    c3_valid = 1'b0;
    check("rd3_lat",  32'(lat3), 32'd5);
    check("rd3_data", rd3,       32'h0000_BEEF);
    $display("xfer cpu rd (RL3) addr=0x10 lat=%0d data=0x%08h", lat3, rd3);

    // Both requesters from reset, four reads each
    resetn = 1'b0;
    cpu_wstrb = 0; dma_wstrb = 0;
    cpu_addr = 32'(8 * 4);   cpu_valid = 1'b1;
    dma_addr = 32'(100 * 4); dma_valid = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    nc = 0; nd = 0; n = 0; both = 0; cpu_pend = 0; dma_pend = 0;
    for (int cyc = 0; cyc < 200 && (nc < 4 || nd < 4); cyc++) begin
      @(negedge clk);
      if (cpu_pend) begin
        cpu_pend = 0;
        if (nc < 4) cpu_addr = 32'((8 + nc) * 4); else cpu_valid = 1'b0;
      end
      if (dma_pend) begin
        dma_pend = 0;
        if (nd < 4) dma_addr = 32'((100 + nd) * 4); else dma_valid = 1'b0;
      end
      if (cpu_ready && dma_ready) both++;
      if (cpu_ready) begin
        check($sformatf("rr_order%0d", n), 32'd0, 32'(n % 2));
        check($sformatf("rr_cpu_data%0d", nc), cpu_rdata, 32'hA500_0000 | 32'(8 + nc));
        $display("xfer rr #%0d cpu data=0x%08h", n, cpu_rdata);
        nc++; n++; cpu_pend = 1;
      end
      if (dma_ready) begin
        check($sformatf("rr_order%0d", n), 32'd1, 32'(n % 2));
        check($sformatf("rr_dma_data%0d", nd), dma_rdata, 32'hA500_0000 | 32'(100 + nd));
        $display("xfer rr #%0d dma data=0x%08h", n, dma_rdata);
        nd++; n++; dma_pend = 1;
      end
    end
    @(negedge clk);
    cpu_valid = 1'b0; dma_valid = 1'b0;
    check("rr_cpu_count", 32'(nc),   32'd4);
    check("rr_dma_count", 32'(nd),   32'd4);
    check("rr_both_hi",   32'(both), 32'd0);

    // DMA out-of-range read (word 512)
    do_xfer(1, 32'h0000_0800, 32'h0, 4'b0000);
    check("oor_lat",   32'(x_lat),   32'd1);
    check("oor_err",   32'(x_err),   32'd1);
    check("oor_ncs",   32'(x_ncs),   32'd0);
    check("oor_rdata", x_rd,         32'd0);
    check("oor_other", 32'(x_other), 32'd0);
    $display("xfer dma rd addr=0x800 lat=%0d err=%0d data=0x%08h", x_lat, x_err, x_rd);

    // Reset while a CPU read sits in WAIT
    cpu_addr = 32'h10; cpu_wstrb = 0; cpu_valid = 1'b1;
    @(negedge clk);           // ACCESS
    @(negedge clk);           // WAIT
    resetn = 1'b0;
    #1;
    check("arst_csb",   32'(sram_csb),  32'd1);
    check("arst_addr",  32'(sram_addr), 32'd0);
    check("arst_ready", 32'({cpu_ready, dma_ready}), 32'd0);
    check("arst_rdata", cpu_rdata,      32'd0);
    cpu_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    hits = 0;
    repeat (4) begin @(negedge clk); if (cpu_ready) hits++; end
    check("arst_no_ready", 32'(hits), 32'd0);
    do_xfer(0, 32'h10, 32'h0, 4'b0000);
    check("arst_rd_lat",  32'(x_lat), 32'd3);
    check("arst_rd_data", x_rd,       32'h0000_BEEF);
    $display("xfer cpu rd after reset lat=%0d data=0x%08h", x_lat, x_rd);

    // Back-to-back CPU requests, DMA idle
    do_xfer(0, 32'(20 * 4), 32'h1234_5678, 4'b1111);
    check("b2b0_lat",  32'(x_lat),      32'd2);
    check("b2b0_idle", 32'(x_post_csb), 32'd1);
    check("b2b0_dup",  32'(x_post_rdy), 32'd0);
    $display("xfer cpu wr addr=0x50 lat=%0d", x_lat);
    do_xfer(0, 32'(20 * 4), 32'h0, 4'b0000);
    check("b2b1_lat",  32'(x_lat),      32'd3);
    check("b2b1_ncs",  32'(x_ncs),      32'd1);
    check("b2b1_data", x_rd,            32'h1234_5678);
    check("b2b1_dup",  32'(x_post_rdy), 32'd0);
    $display("xfer cpu rd addr=0x50 lat=%0d data=0x%08h", x_lat, x_rd);
    do_xfer(0, 32'(21 * 4), 32'h0, 4'b0000);
    check("b2b2_lat",  32'(x_lat), 32'd3);
    check("b2b2_data", x_rd,       32'hA500_0015);
    $display("xfer cpu rd addr=0x54 lat=%0d data=0x%08h", x_lat, x_rd);
    hits = 0;
    repeat (3) begin @(negedge clk); if (cpu_ready || dma_ready) hits++; end
    check("b2b_tail_ready", 32'(hits), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
